cook_sequencer: RTL and testbench
=================================

# cook_sequencer

Top-level cooking controller for the microwave design: turns front-panel buttons, the door switch and the power-level selector into the start/stop/pause pulses and min/sec setpoint consumed by the countdown timer. It gates the magnetron with a power-level duty cycle and a door interlock, and drives lamp, turntable and end-of-cook beeper. It sits between the debounced panel inputs and the timer, all in the `clock` domain.

## Interface
- `LOAD_WAIT`, 256: cycles `tmr_min`/`tmr_sec` are held stable before `tmr_start` is pulsed (must exceed one timer tick period).
- `ARM_TIMEOUT`, 8: cycles allowed for `timer_done` to fall after a start pulse.
- `POWER_PERIOD`, 400: magnetron duty window length in cycles (multiple of 4).
- `BEEP_CYCLES`, 1000: beeper on-time at end of cook.
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `door_open` in 1: door switch level, 1 = open.
- `btn_start`, `btn_stop`, `btn_quick` in 1: debounced synchronous button levels; the block edge-detects internally.
- `set_min` in 7: requested minutes. `set_sec` in 7: requested seconds.
- `power_lvl` in 2: 0..3 = 25/50/75/100 % duty.
- `timer_done` in 1: timer idle flag (1 = idle).
- `tmr_start`, `tmr_stop`, `tmr_pause` out 1: single-cycle command pulses to the timer.
- `tmr_min`, `tmr_sec` out 7: setpoint to the timer.
- `magnetron` out 1: heater enable. `lamp`, `turntable`, `beep` out 1.
- `state` out 3: current state code, for debug and LEDs.

## Operation
- Rising edge of each button = current level 1 and registered previous level 0. Previous levels reset to 0.
- State codes: IDLE=0, LOAD=1, START=2, ARMING=3, COOK=4, PAUSED=5, FINISH=6.
- IDLE, btn_start edge, door closed: capture the clamped setpoint (min ≤ 99, sec ≤ 59). If the setpoint is 0:00, stay in IDLE; otherwise go to LOAD.
- IDLE, btn_quick edge, door closed: setpoint = 0:30, go to LOAD. btn_start takes priority over btn_quick when both occur.
- Any button edge with the door open is ignored in IDLE.
- LOAD: counts LOAD_WAIT cycles with the setpoint driven, then goes to START.
- START: asserts `tmr_start` for exactly 1 cycle, then goes to ARMING.
- ARMING: on `timer_done`=0, go to COOK. If ARM_TIMEOUT cycles pass first, pulse `tmr_stop` and go to IDLE.
- In ARMING, door open or btn_stop edge: pulse `tmr_stop` and go to IDLE.
- COOK, priority highest first:
  - btn_stop edge: pulse `tmr_stop`, go to IDLE.
  - door_open: pulse `tmr_pause`, go to PAUSED.
  - timer_done=1: go to FINISH.
- PAUSED, priority highest first:
  - btn_stop edge: pulse `tmr_stop`, go to IDLE.
  - btn_start edge with the door closed: pulse `tmr_start`, go to ARMING.
  - Door state alone never resumes.
- FINISH: `beep`=1 for BEEP_CYCLES, then go to IDLE. A btn_stop edge or door_open ends the beep and goes to IDLE immediately.
- `tmr_min`/`tmr_sec` hold the captured setpoint in every state. Reset value is 0:00.
- Duty counter: free-runs 0..POWER_PERIOD-1 while in COOK and is cleared to 0 on entry to COOK. `duty_on` = counter < (power_lvl+1)·POWER_PERIOD/4.
- `magnetron` = registered (state==COOK & duty_on), ANDed combinationally with !door_open. The door interlock therefore has zero-cycle latency.
- `turntable` = state is COOK. `lamp` = door_open or state is COOK or PAUSED. `beep` = state is FINISH.

## Timing
- Reset: state=IDLE. All outputs are 0, including `tmr_*` pulses and setpoint. All counters are 0. Reset mid-operation aborts without issuing `tmr_stop`, since the timer shares the reset.
- Outputs are registered, except the interlock AND on `magnetron` and the `lamp` door term.
- The button edge is seen in the cycle after the level rises. The state change is on the next clock.
- IDLE→LOAD→START: `tmr_start` rises LOAD_WAIT+1 cycles after the cycle in which the edge is detected.
- Pulses are never back-to-back. At most one `tmr_*` pulse fires per cycle.
- A power_lvl change takes effect at the next duty comparison; there is no window restart.
- Setpoint changes on `set_min`/`set_sec` are ignored outside the IDLE capture.

## Test plan
- Normal cook: set 0:02, power 3, start, then the bench timer model drops and later raises done → `tmr_start` 1 cycle after LOAD_WAIT; `magnetron` is held 1 throughout COOK; FINISH with `beep` for exactly BEEP_CYCLES; back to IDLE.
- Door open mid-cook → `magnetron` is 0 in the same cycle, `tmr_pause` is one pulse, state=5, `lamp`=1. Close the door: no resume. Press start → `tmr_start` pulse, ARMING, then COOK.
- Clamp and zero: set 120:75 → `tmr_min`=99, `tmr_sec`=59. Set 0:00 with start → stays IDLE with no pulses.
- Quick start with the door closed → setpoint 0:30. btn_start and btn_quick in the same cycle → the set_min/set_sec value is used.
- Power 0 with POWER_PERIOD=400 → `magnetron` is high exactly 100 of every 400 cycles. Stop during COOK → `tmr_stop` pulse and IDLE.
- Arming timeout: `timer_done` held at 1 → `tmr_stop` pulse ARM_TIMEOUT cycles after START, then IDLE. Reset asserted in COOK → all outputs 0 immediately.

Source files
------------

// File: rtl/cook_sequencer.sv
// Microwave cooking controller: turns panel buttons, door switch and power level
// into timer command pulses, a setpoint, and magnetron/lamp/turntable/beeper drives.
module cook_sequencer #(
    parameter int LOAD_WAIT    = 256,
    parameter int ARM_TIMEOUT  = 8,
    parameter int POWER_PERIOD = 400,
    parameter int BEEP_CYCLES  = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       door_open,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_quick,
    input  logic [6:0] set_min,
    input  logic [6:0] set_sec,
    input  logic [1:0] power_lvl,
    input  logic       timer_done,
    output logic       tmr_start,
    output logic       tmr_stop,
    output logic       tmr_pause,
    output logic [6:0] tmr_min,
    output logic [6:0] tmr_sec,
    output logic       magnetron,
    output logic       lamp,
    output logic       turntable,
    output logic       beep,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_START  = 3'd2,
        S_ARMING = 3'd3,
        S_COOK   = 3'd4,
        S_PAUSED = 3'd5,
        S_FINISH = 3'd6
    } state_t;

    localparam int MAX_A   = (LOAD_WAIT > BEEP_CYCLES) ? LOAD_WAIT : BEEP_CYCLES;
    localparam int CNT_MAX = (MAX_A > ARM_TIMEOUT) ? MAX_A : ARM_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int DW      = $clog2(POWER_PERIOD + 1);
    localparam int QUARTER = POWER_PERIOD / 4;

    state_t state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [DW-1:0] duty_reg, duty_next;
    logic [DW-1:0] duty_thresh;
    logic [6:0] min_reg, min_next, sec_reg, sec_next;
    logic [6:0] min_clamped, sec_clamped;
    logic start_reg, start_next, stop_reg, stop_next, pause_reg, pause_next;
    logic pend_stop_reg, pend_stop_next, pend_start_reg, pend_start_next;
    logic mag_reg, mag_next, lamp_reg, lamp_next, turn_reg, turn_next, beep_reg, beep_next;

    logic [2:0] btn_vec;
    logic [2:0] edge_vec;
    logic start_edge, stop_edge, quick_edge;
    logic start_ev, stop_ev, busy;

    assign btn_vec = {btn_quick, btn_stop, btn_start};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_edge
            logic prev_reg;
            always_ff @(posedge clock or posedge reset) begin
                if (reset) prev_reg <= 1'b0;
                else       prev_reg <= btn_vec[gi];
            end
            assign edge_vec[gi] = btn_vec[gi] & ~prev_reg;
        end
    endgenerate

    assign start_edge = edge_vec[0];
    assign stop_edge  = edge_vec[1];
    assign quick_edge = edge_vec[2];

    // A button edge arriving while a command pulse is out is held over one cycle,
    // so two timer pulses can never land in consecutive cycles.
    assign start_ev = start_edge | pend_start_reg;
    assign stop_ev  = stop_edge | pend_stop_reg;
    assign busy     = start_reg | stop_reg | pause_reg;

    assign min_clamped = (set_min > 7'd99) ? 7'd99 : set_min;
    assign sec_clamped = (set_sec > 7'd59) ? 7'd59 : set_sec;

    always_comb begin
        state_next      = state_reg;
        cnt_next        = '0;
        min_next        = min_reg;
        sec_next        = sec_reg;
        start_next      = 1'b0;
        stop_next       = 1'b0;
        pause_next      = 1'b0;
        pend_stop_next  = 1'b0;
        pend_start_next = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start_edge && !door_open) begin
                    min_next = min_clamped;
                    sec_next = sec_clamped;
                    if (set_min != 7'd0 || set_sec != 7'd0) state_next = S_LOAD;
                end else if (quick_edge && !door_open) begin
                    min_next   = 7'd0;
                    sec_next   = 7'd30;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (cnt_reg == CW'(LOAD_WAIT - 1)) begin
                    state_next = S_START;
                    start_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_START: begin
                state_next = S_ARMING;
                cnt_next   = cnt_reg + CW'(1);
            end
            S_ARMING: begin
                // cnt_reg counts cycles since the start pulse went out
                if (busy) begin
                    cnt_next       = cnt_reg + CW'(1);
                    pend_stop_next = stop_ev;
                end else if (stop_ev || door_open) begin
                    state_next = S_IDLE;
                    stop_next  = 1'b1;
                end else if (!timer_done) begin
                    state_next = S_COOK;
                end else if (cnt_reg >= CW'(ARM_TIMEOUT - 1)) begin
                    state_next = S_IDLE;
                    stop_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_COOK: begin
                if (stop_edge) begin
                    state_next = S_IDLE;
                    stop_next  = 1'b1;
                end else if (door_open) begin
                    state_next = S_PAUSED;
                    pause_next = 1'b1;
                end else if (timer_done) begin
                    state_next = S_FINISH;
                end
            end
            S_PAUSED: begin
                if (busy) begin
                    pend_stop_next  = stop_ev;
                    pend_start_next = start_ev;
                end else if (stop_ev) begin
                    state_next = S_IDLE;
                    stop_next  = 1'b1;
                end else if (start_ev && !door_open) begin
                    state_next = S_ARMING;
                    start_next = 1'b1;
                end
            end
            S_FINISH: begin
                if (stop_edge || door_open || cnt_reg == CW'(BEEP_CYCLES - 1)) begin
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Duty window restarts on COOK entry; thresholds follow power_lvl live.
    always_comb begin
        duty_next = '0;
        if (state_next == S_COOK && state_reg == S_COOK) begin
            duty_next = (duty_reg == DW'(POWER_PERIOD - 1)) ? '0 : duty_reg + DW'(1);
        end
        duty_thresh = (DW'(power_lvl) + DW'(1)) * DW'(QUARTER);
        mag_next    = (state_next == S_COOK) && (duty_next < duty_thresh);
        lamp_next   = (state_next == S_COOK) || (state_next == S_PAUSED);
        turn_next   = (state_next == S_COOK);
        beep_next   = (state_next == S_FINISH);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            duty_reg       <= '0;
            min_reg        <= '0;
            sec_reg        <= '0;
            start_reg      <= 1'b0;
            stop_reg       <= 1'b0;
            pause_reg      <= 1'b0;
            pend_stop_reg  <= 1'b0;
            pend_start_reg <= 1'b0;
            mag_reg        <= 1'b0;
            lamp_reg       <= 1'b0;
            turn_reg       <= 1'b0;
            beep_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            duty_reg       <= duty_next;
            min_reg        <= min_next;
            sec_reg        <= sec_next;
            start_reg      <= start_next;
            stop_reg       <= stop_next;
            pause_reg      <= pause_next;
            pend_stop_reg  <= pend_stop_next;
            pend_start_reg <= pend_start_next;
            mag_reg        <= mag_next;
            lamp_reg       <= lamp_next;
            turn_reg       <= turn_next;
            beep_reg       <= beep_next;
        end
    end

    assign tmr_start = start_reg;
    assign tmr_stop  = stop_reg;
    assign tmr_pause = pause_reg;
    assign tmr_min   = min_reg;
    assign tmr_sec   = sec_reg;
    assign magnetron = mag_reg & ~door_open;
    assign lamp      = lamp_reg | door_open;
    assign turntable = turn_reg;
    assign beep      = beep_reg;
    assign state     = state_reg;

endmodule

// File: tb/tb_cook_sequencer.sv
// Self-checking bench for cook_sequencer: capture vector table, hand-written cook
// sequences, and randomized capture/duty checks against an arithmetic model.
module tb_cook_sequencer;

    localparam int LOAD_WAIT    = 256;
    localparam int ARM_TIMEOUT  = 8;
    localparam int POWER_PERIOD = 400;
    localparam int BEEP_CYCLES  = 1000;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       door_open = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_stop = 1'b0;
    logic       btn_quick = 1'b0;
    logic [6:0] set_min = 7'd0;
    logic [6:0] set_sec = 7'd0;
    logic [1:0] power_lvl = 2'd0;
    logic       timer_done = 1'b1;
    logic       tmr_start, tmr_stop, tmr_pause;
    logic [6:0] tmr_min, tmr_sec;
    logic       magnetron, lamp, turntable, beep;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    cook_sequencer #(
        .LOAD_WAIT(LOAD_WAIT), .ARM_TIMEOUT(ARM_TIMEOUT),
        .POWER_PERIOD(POWER_PERIOD), .BEEP_CYCLES(BEEP_CYCLES)
    ) dut (
        .clock(clock), .reset(reset), .door_open(door_open),
        .btn_start(btn_start), .btn_stop(btn_stop), .btn_quick(btn_quick),
        .set_min(set_min), .set_sec(set_sec), .power_lvl(power_lvl),
        .timer_done(timer_done), .tmr_start(tmr_start), .tmr_stop(tmr_stop),
        .tmr_pause(tmr_pause), .tmr_min(tmr_min), .tmr_sec(tmr_sec),
        .magnetron(magnetron), .lamp(lamp), .turntable(turntable),
        .beep(beep), .state(state)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       door;
        logic       start;
        logic       quick;
        logic [6:0] min;
        logic [6:0] sec;
        int         exp_state;
        int         exp_min;
        int         exp_sec;
        int         exp_lamp;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        btn_start = 1'b0; btn_stop = 1'b0; btn_quick = 1'b0;
        door_open = 1'b0; timer_done = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_start(input int limit, output int n);
        n = 0;
        while (!tmr_start && n < limit) begin
            tick();
            n++;
        end
        if (!tmr_start) begin
            checks++;
            errors++;
            $display("FAIL wait_tmr_start: got no pulse in %0d cycles, expected a pulse", n);
        end
    endtask

    // Drive a full start sequence up to the first COOK cycle.
    task automatic go_cook(input int m, input int s, input int lvl);
        int n;
        reset_dut();
        set_min = 7'(m); set_sec = 7'(s); power_lvl = 2'(lvl);
        btn_start = 1'b1;
        tick();
        btn_start = 1'b0;
        wait_start(LOAD_WAIT + 20, n);
        tick();
        timer_done = 1'b0;
        tick();
    endtask

    function automatic int count_window_expect(input int lvl);
        return (lvl + 1) * POWER_PERIOD / 4;
    endfunction

    initial begin
        int n, hi, bl, lvl, rm, rs, em, es, est;
        logic rd, rst_b, rq;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 7'd120, 7'd75, 1, 99, 59, 0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 7'd0,   7'd0,  0, 0,  0,  0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 7'd5,   7'd5,  1, 0,  30, 0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 7'd3,   7'd10, 1, 3,  10, 0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 7'd10,  7'd10, 0, 0,  0,  1};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 7'd10,  7'd10, 0, 0,  0,  1};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 7'd99,  7'd59, 1, 99, 59, 0};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 7'd100, 7'd60, 1, 99, 59, 0};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 7'd7,   7'd7,  0, 0,  0,  0};
        vecs[9] = '{1'b0, 1'b1, 1'b0, 7'd0,   7'd1,  1, 0,  1,  0};

        // Reset state
        reset_dut();
        chk("reset_state", int'(state), 0);
        chk("reset_outputs", int'({tmr_start, tmr_stop, tmr_pause, magnetron, lamp, turntable, beep}), 0);
        chk("reset_setpoint", int'({tmr_min, tmr_sec}), 0);

        // Capture table
        for (int i = 0; i < 10; i++) begin
            reset_dut();
            door_open = vecs[i].door;
            set_min = vecs[i].min; set_sec = vecs[i].sec;
            btn_start = vecs[i].start; btn_quick = vecs[i].quick;
            tick();
            btn_start = 1'b0; btn_quick = 1'b0;
            chk($sformatf("vec%0d_state", i), int'(state), vecs[i].exp_state);
            chk($sformatf("vec%0d_min", i), int'(tmr_min), vecs[i].exp_min);
            chk($sformatf("vec%0d_sec", i), int'(tmr_sec), vecs[i].exp_sec);
            chk($sformatf("vec%0d_lamp", i), int'(lamp), vecs[i].exp_lamp);
            chk($sformatf("vec%0d_pulses", i), int'({tmr_start, tmr_stop, tmr_pause}), 0);
        end

        // Normal cook at 0:02, full power
        reset_dut();
        set_min = 7'd0; set_sec = 7'd2; power_lvl = 2'd3;
        btn_start = 1'b1;
        tick();
        btn_start = 1'b0;
        chk("cook_load_state", int'(state), 1);
        set_min = 7'd44;
        tick();
        chk("cook_setpoint_held", int'(tmr_min), 0);
        wait_start(LOAD_WAIT + 20, n);
        chk("cook_start_latency", n + 2, LOAD_WAIT + 1);
        chk("cook_start_state", int'(state), 2);
        tick();
        chk("cook_arming_state", int'(state), 3);
        chk("cook_start_width", int'(tmr_start), 0);
        timer_done = 1'b0;
        tick();
        chk("cook_cook_state", int'(state), 4);
        chk("cook_turn_lamp", int'({turntable, lamp}), 3);
        hi = 0;
        for (int c = 0; c < 50; c++) begin
            if (magnetron) hi++;
            tick();
        end
        chk("cook_mag_full_power", hi, 50);
        timer_done = 1'b1;
        tick();
        chk("cook_finish_state", int'(state), 6);
        chk("cook_finish_mag", int'(magnetron), 0);
        bl = 0;
        while (beep && bl < 2000) begin
            bl++;
            tick();
        end
        chk("cook_beep_len", bl, BEEP_CYCLES);
        chk("cook_back_idle", int'(state), 0);

        // Door open mid-cook, no resume on close, restart with start
        go_cook(0, 10, 3);
        chk("door_pre_mag", int'(magnetron), 1);
        door_open = 1'b1;
        #1;
        chk("door_mag_same_cycle", int'(magnetron), 0);
        tick();
        chk("door_paused_state", int'(state), 5);
        chk("door_pause_pulse", int'(tmr_pause), 1);
        chk("door_lamp", int'(lamp), 1);
        tick();
        chk("door_pause_width", int'(tmr_pause), 0);
        door_open = 1'b0;
        tick(); tick(); tick();
        chk("door_no_resume", int'(state), 5);
        btn_start = 1'b1;
        tick();
        btn_start = 1'b0;
        chk("resume_arming", int'(state), 3);
        chk("resume_start_pulse", int'(tmr_start), 1);
        tick();
        tick();
        chk("resume_cook", int'(state), 4);

        // Power 0 duty, then stop during COOK
        go_cook(1, 0, 0);
        hi = 0;
        for (int c = 0; c < POWER_PERIOD; c++) begin
            if (magnetron) hi++;
            tick();
        end
        chk("duty_power0", hi, 100);
        btn_stop = 1'b1;
        tick();
        btn_stop = 1'b0;
        chk("stop_state", int'(state), 0);
        chk("stop_pulse", int'(tmr_stop), 1);
        tick();
        chk("stop_width", int'(tmr_stop), 0);

        // Arming timeout with the timer never leaving idle
        reset_dut();
        set_min = 7'd0; set_sec = 7'd5;
        btn_start = 1'b1;
        tick();
        btn_start = 1'b0;
        wait_start(LOAD_WAIT + 20, n);
        n = 0;
        while (!tmr_stop && n < 50) begin
            tick();
            n++;
        end
        chk("arm_timeout_cycles", n, ARM_TIMEOUT);
        chk("arm_timeout_idle", int'(state), 0);
        tick();
        chk("arm_timeout_width", int'(tmr_stop), 0);

        // Asynchronous reset in COOK
        go_cook(1, 0, 2);
        chk("rst_pre_cook", int'(state), 4);
        reset = 1'b1;
        #1;
        chk("rst_async_state", int'(state), 0);
        chk("rst_async_outputs", int'({tmr_start, tmr_stop, tmr_pause, magnetron, lamp, turntable, beep}), 0);
        chk("rst_async_setpoint", int'({tmr_min, tmr_sec}), 0);
        tick();
        reset = 1'b0;
        tick();

        // Randomized capture against the front-panel rules
        for (int i = 0; i < 16; i++) begin
            rm = int'($urandom_range(0, 127));
            rs = int'($urandom_range(0, 127));
            rd = 1'($urandom_range(0, 1));
            rst_b = 1'($urandom_range(0, 1));
            rq = 1'($urandom_range(0, 1));
            em = 0; es = 0; est = 0;
            if (!rd && rst_b) begin
                em = (rm > 99) ? 99 : rm;
                es = (rs > 59) ? 59 : rs;
                est = (em + es == 0) ? 0 : 1;
            end else if (!rd && rq) begin
                em = 0; es = 30; est = 1;
            end
            reset_dut();
            door_open = rd; set_min = 7'(rm); set_sec = 7'(rs);
            btn_start = rst_b; btn_quick = rq;
            tick();
            btn_start = 1'b0; btn_quick = 1'b0;
            chk($sformatf("rnd%0d_cap d=%0d s=%0d q=%0d %0d:%0d", i, rd, rst_b, rq, rm, rs),
                int'({state, tmr_min, tmr_sec}), (est << 14) | (em << 7) | es);
        end

        // Randomized power level duty over one full window
        for (int i = 0; i < 4; i++) begin
            lvl = int'($urandom_range(0, 3));
            go_cook(2, 0, lvl);
            hi = 0;
            for (int c = 0; c < POWER_PERIOD; c++) begin
                if (magnetron) hi++;
                tick();
            end
            chk($sformatf("rnd_duty lvl=%0d", lvl), hi, count_window_expect(lvl));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
